// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: issues one request at a time over the
// instruction SRAM-like bus and buffers the returned word for decode.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state;
    logic        req_q;
    logic        discard;
    logic [31:0] pc;
    logic [31:0] pend;
    logic [63:0] buf_q;
    logic [31:0] tgt;
    logic        accept;

    assign tgt    = {br_target[31:2], 2'b00};
    // req_q is only ever high in S_REQ; it stays low for the first cycle
    // after reset so nothing is presented while the bridge wakes up.
    assign accept = (state == S_REQ) & req_q & inst_sram_addr_ok;

    assign inst_sram_req   = req_q;
    assign inst_sram_addr  = pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    // A redirect in the same cycle hides the buffered instruction.
    assign fs_to_ds_valid = (state == S_HOLD) & ~br_taken;
    assign fs_to_ds_bus   = buf_q;

    // Fetch FSM: request, wait for response, hold for decode.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_REQ;
            req_q   <= 1'b0;
            discard <= 1'b0;
            pc      <= RESET_PC;
            pend    <= 32'h0;
            buf_q   <= 64'h0;
        end else begin
            unique case (state)
                S_REQ: begin
                    req_q <= ~accept;
                    if (accept) begin
                        state <= S_WAIT;
                    end
                    // Request already in flight or committed: its
                    // response must be thrown away later.
                    if (br_taken) begin
                        discard <= 1'b1;
                        pend    <= tgt;
                    end
                end
                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        if (discard | br_taken) begin
                            discard <= 1'b0;
                            pc      <= br_taken ? tgt : pend;
                            state   <= S_REQ;
                            req_q   <= 1'b1;
                        end else begin
                            buf_q <= {inst_sram_rdata, pc};
                            state <= S_HOLD;
                        end
                    end else if (br_taken) begin
                        discard <= 1'b1;
                        pend    <= tgt;
                    end
                end
                S_HOLD: begin
                    if (br_taken) begin
                        pc    <= tgt;
                        state <= S_REQ;
                        req_q <= 1'b1;
                    end else if (ds_allowin) begin
                        pc    <= pc + 32'd4;
                        state <= S_REQ;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= S_REQ;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
